camellia_core_sched: RTL and testbench
======================================

CAMELLIA_CORE_SCHED -- requirements
Module: camellia_core_sched

Interface
REQ-001 SHALL have parameter LATENCY, default 24: cycles from core issue to valid result at core_res; legal range 1..63.
REQ-002 SHALL have port CLK, input, 1: single clock; all logic rising-edge.
REQ-003 SHALL have port RST, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid (input, 1), req0_dec (input, 1; 1 = decrypt), req0_data (input, 128), req0_key (input, 128): requester 0 block request.
REQ-005 SHALL have port req0_ready, output, 1: request 0 accepted this cycle when high with req0_valid.
REQ-006 SHALL have ports req1_valid, req1_dec, req1_data, req1_key (inputs) and req1_ready (output), widths as REQ-004/REQ-005: requester 1.
REQ-007 SHALL have ports core_valid (output, 1), core_dec (output, 1), core_data (output, 128), core_key (output, 128): issue to the shared pipelined encrypt/decrypt core.
REQ-008 SHALL have port core_res, input, 128: core result, valid exactly LATENCY cycles after the matching core_valid.
REQ-009 SHALL have ports rsp0_valid, rsp1_valid (outputs, 1) and rsp_data (output, 128): one-cycle result pulse to the owning requester; no backpressure.
REQ-010 SHALL have ports flush (input, 1) and flush_done (output, 1): drain request and one-cycle completion pulse.
REQ-011 SHALL have port busy, output, 1: high when any operation is in flight.

Function
REQ-012 SHALL implement states IDLE, RUN, DRAIN: IDLE->RUN on accepted request; RUN->IDLE when in-flight count reaches 0 with no accept that cycle; IDLE/RUN->DRAIN on flush=1; DRAIN->IDLE when in-flight count is 0, pulsing flush_done for that one cycle.
REQ-013 SHALL accept at most one request per cycle; ready is combinational and never high for both requesters in the same cycle.
REQ-014 SHALL arbitrate round-robin: when both are valid, grant the requester not granted last; after reset, requester 0 has priority.
REQ-015 SHALL deassert both ready signals in DRAIN and in the cycle flush is sampled high.
REQ-016 SHALL register the granted request: core_valid/core_dec/core_data/core_key update one cycle after acceptance; core_valid is high for exactly one cycle per accepted request.
REQ-017 SHALL track ownership in a LATENCY-deep shift register of {valid, owner}, entered at core issue; on its output, assert rsp0_valid or rsp1_valid per owner and drive rsp_data = core_res in the same cycle.
REQ-018 SHALL keep a 7-bit in-flight counter: +1 on core issue, -1 on response, unchanged when both occur in the same cycle; busy = (counter != 0) or core_valid.
REQ-019 SHALL, when a request is held by ready=0, not alter its data; requesters hold request fields stable while valid is high.
REQ-020 SHALL ignore flush while already in DRAIN; flush in IDLE with counter 0 pulses flush_done on the next cycle.

Reset
REQ-021 SHALL, on RST=1 at a clock edge: state=IDLE, counter=0, shift register cleared, round-robin pointer = requester 0 priority, all valid/ready/flush_done/busy outputs 0, core_data/core_key/rsp_data 0.
REQ-022 SHALL discard in-flight operations on mid-operation reset; no rsp pulse for operations issued before reset.

Configuration
REQ-023 SHALL, with macro CAMELLIA_SCHED_STATS_EN defined, add outputs enc_count and dec_count (32 bits each; issued encryptions/decryptions, wrap at 2^32, reset to 0); without it, these ports and counters are absent and behaviour is otherwise identical.

Verification
REQ-024 SHALL cover: req0 only, dec=0, data=0x0123456789ABCDEFFEDCBA9876543210 -> core_valid 1 cycle later, rsp0_valid exactly LATENCY cycles after core_valid, rsp_data=core_res.
REQ-025 SHALL cover: both valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; responses return in issue order to matching owner.
REQ-026 SHALL cover: flush asserted with 5 ops in flight -> ready low immediately, flush_done pulses one cycle after last response, then IDLE.
REQ-027 SHALL cover: RST asserted mid-stream with 3 ops in flight -> no rsp pulses afterwards, busy=0, next grant goes to requester 0.
REQ-028 SHALL cover: issue and response in the same cycle -> in-flight count unchanged; with CAMELLIA_SCHED_STATS_EN defined, 3 enc + 2 dec issues -> enc_count=3, dec_count=2.

Source files
------------

// File: rtl/camellia_core_sched.sv
// camellia_core_sched: two-requester round-robin front end for a shared,
// fixed-latency pipelined Camellia encrypt/decrypt core. It registers the
// granted request towards the core, tracks the owner of every in-flight
// operation in a LATENCY-deep shift register, and routes each core result
// back to its requester as a one-cycle pulse. A flush stops new grants
// until every in-flight operation has returned.
//
// Optional build macro: CAMELLIA_SCHED_STATS_EN adds the enc_count and
// dec_count issue counters.
//
// state | meaning
// IDLE  | nothing in flight, accepting requests
// RUN   | operations in flight, accepting requests
// DRAIN | flush in progress, no grants until in-flight count is zero
module camellia_core_sched #(
  parameter int LATENCY = 24
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         req0_valid,
  input  logic         req0_dec,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic         req1_dec,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic         req1_ready,
  output logic         core_valid,
  output logic         core_dec,
  output logic [127:0] core_data,
  output logic [127:0] core_key,
  input  logic [127:0] core_res,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [127:0] rsp_data,
  input  logic         flush,
  output logic         flush_done,
  output logic         busy
`ifdef CAMELLIA_SCHED_STATS_EN
  ,
  output logic [31:0]  enc_count,
  output logic [31:0]  dec_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_prio0;       // 1: requester 0 wins a tie
  logic               r_core_owner;
  logic [LATENCY-1:0] r_sh_vld;
  logic [LATENCY-1:0] r_sh_own;
  logic [6:0]         r_inflight;

  logic w_accept_ok;
  logic w_gnt0;
  logic w_gnt1;
  logic w_accept;
  logic w_rsp_vld;
  logic w_rsp_own;
  logic w_empty;

  // Grants are blocked during reset, while draining, and in the flush cycle.
  assign w_accept_ok = !RST && (r_state != DRAIN) && !flush;
  assign w_gnt0      = req0_valid && (!req1_valid || r_prio0);
  assign w_gnt1      = req1_valid && (!req0_valid || !r_prio0);
  assign req0_ready  = w_accept_ok && w_gnt0;
  assign req1_ready  = w_accept_ok && w_gnt1;
  assign w_accept    = req0_ready || req1_ready;

  assign w_rsp_vld   = r_sh_vld[LATENCY-1];
  assign w_rsp_own   = r_sh_own[LATENCY-1];
  assign rsp0_valid  = w_rsp_vld && !w_rsp_own;
  assign rsp1_valid  = w_rsp_vld && w_rsp_own;
  assign rsp_data    = w_rsp_vld ? core_res : '0;

  // An issue sitting on the core outputs is not yet counted, so include it.
  assign w_empty     = (r_inflight == 7'd0) && !core_valid;
  assign busy        = !w_empty;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and the drain-complete pulse.
  always_comb begin
    w_state_nxt = r_state;
    flush_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (flush)         w_state_nxt = DRAIN;
        else if (w_accept) w_state_nxt = RUN;
      end
      RUN: begin
        if (flush)                     w_state_nxt = DRAIN;
        else if (w_empty && !w_accept) w_state_nxt = IDLE;
      end
      DRAIN: begin
        if (w_empty) begin
          w_state_nxt = IDLE;
          flush_done  = !RST;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Register the granted request towards the core and move the round-robin pointer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      core_valid   <= 1'b0;
      core_dec     <= 1'b0;
      core_data    <= '0;
      core_key     <= '0;
      r_core_owner <= 1'b0;
      r_prio0      <= 1'b1;
    end else begin
      core_valid <= w_accept;
      if (w_accept) begin
        core_dec     <= req1_ready ? req1_dec  : req0_dec;
        core_data    <= req1_ready ? req1_data : req0_data;
        core_key     <= req1_ready ? req1_key  : req0_key;
        r_core_owner <= req1_ready;
        r_prio0      <= req1_ready;
      end
    end
  end

  // Ownership pipeline aligned with the core latency.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sh_vld <= '0;
      r_sh_own <= '0;
    end else begin
      r_sh_vld[0] <= core_valid;
      r_sh_own[0] <= r_core_owner;
      for (int i = 1; i < LATENCY; i++) begin
        r_sh_vld[i] <= r_sh_vld[i-1];
        r_sh_own[i] <= r_sh_own[i-1];
      end
    end
  end

  // In-flight counter: issue and response in the same cycle cancel out.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_inflight <= 7'd0;
    end else begin
      unique case ({core_valid, w_rsp_vld})
        2'b10:   r_inflight <= r_inflight + 7'd1;
        2'b01:   r_inflight <= r_inflight - 7'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

`ifdef CAMELLIA_SCHED_STATS_EN
  // Issue statistics, split by direction; wrap naturally at 2^32.
  always_ff @(posedge CLK) begin
    if (RST) begin
      enc_count <= '0;
      dec_count <= '0;
    end else if (core_valid) begin
      if (core_dec) dec_count <= dec_count + 32'd1;
      else          enc_count <= enc_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_camellia_core_sched.sv
// Self-checking bench for camellia_core_sched: a stand-in fixed-latency core,
// a transaction-level reference (expected issue, response queue, drain flag)
// checked every cycle, and directed scenario tasks.
module tb_camellia_core_sched;

  localparam int LATENCY = 24;

  logic         CLK;
  logic         RST;
  logic         req0_valid, req0_dec, req0_ready;
  logic [127:0] req0_data, req0_key;
  logic         req1_valid, req1_dec, req1_ready;
  logic [127:0] req1_data, req1_key;
  logic         core_valid, core_dec;
  logic [127:0] core_data, core_key, core_res;
  logic         rsp0_valid, rsp1_valid;
  logic [127:0] rsp_data;
  logic         flush, flush_done, busy;
`ifdef CAMELLIA_SCHED_STATS_EN
  logic [31:0]  enc_count, dec_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  camellia_core_sched #(.LATENCY(LATENCY)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_dec(req0_dec), .req0_data(req0_data),
    .req0_key(req0_key), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dec(req1_dec), .req1_data(req1_data),
    .req1_key(req1_key), .req1_ready(req1_ready),
    .core_valid(core_valid), .core_dec(core_dec), .core_data(core_data),
    .core_key(core_key), .core_res(core_res),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .flush(flush), .flush_done(flush_done), .busy(busy)
`ifdef CAMELLIA_SCHED_STATS_EN
    , .enc_count(enc_count), .dec_count(dec_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [127:0] core_fn(input logic d, input logic [127:0] x,
                                           input logic [127:0] k);
    return x ^ {k[63:0], k[127:64]} ^ {128{d}};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in core: result of an issue appears exactly LATENCY cycles later.
  logic [127:0] pipe [$];
  always @(posedge CLK) begin
    #1;
    pipe.push_back(core_valid ? core_fn(core_dec, core_data, core_key) : rnd128());
    while (pipe.size() > LATENCY + 1) pipe.delete(0);
    core_res = (pipe.size() == LATENCY + 1) ? pipe[0] : rnd128();
  end

  // Reference model state.
  typedef struct { int due; bit own; logic [127:0] res; } rsp_t;
  rsp_t         q[$];
  int           cyc = 0;
  bit           pend_v, pend_own, pend_dec, draining, prio0;
  logic [127:0] pend_data, pend_key;
  int           exp_enc, exp_dec;
  bit           e0, e1, fd_exp, er0, er1, blk;
  logic [127:0] ed;

  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      q.delete();
      pend_v = 0; draining = 0; prio0 = 1; exp_enc = 0; exp_dec = 0;
    end else begin
`ifdef CAMELLIA_SCHED_STATS_EN
      n_chk++;
      if (enc_count !== exp_enc || dec_count !== exp_dec) begin
        n_fail++;
        $display("FAIL stats cyc=%0d enc=%0d/%0d dec=%0d/%0d", cyc, enc_count, exp_enc, dec_count, exp_dec);
      end
`endif
      n_chk++;
      if (core_valid !== pend_v) begin
        n_fail++;
        $display("FAIL issue_valid cyc=%0d got=%b exp=%b", cyc, core_valid, pend_v);
      end
      if (pend_v) begin
        n_chk++;
        if ({core_dec, core_data, core_key} !== {pend_dec, pend_data, pend_key}) begin
          n_fail++;
          $display("FAIL issue_fields cyc=%0d got=%b/%h exp=%b/%h", cyc, core_dec, core_data, pend_dec, pend_data);
        end
        q.push_back('{due: cyc + LATENCY, own: pend_own, res: core_fn(pend_dec, pend_data, pend_key)});
        if (pend_dec) exp_dec++; else exp_enc++;
      end
      n_chk++;
      if (busy !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, q.size() != 0);
      end
      fd_exp = draining && (q.size() == 0);
      n_chk++;
      if (flush_done !== fd_exp) begin
        n_fail++;
        $display("FAIL flush_done cyc=%0d got=%b exp=%b", cyc, flush_done, fd_exp);
      end
      e0 = 0; e1 = 0; ed = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e0 = !q[0].own; e1 = q[0].own; ed = q[0].res;
        q.delete(0);
      end
      n_chk++;
      if ({rsp0_valid, rsp1_valid} !== {e0, e1}) begin
        n_fail++;
        $display("FAIL rsp_valid cyc=%0d got=%b%b exp=%b%b", cyc, rsp0_valid, rsp1_valid, e0, e1);
      end
      if (e0 || e1) begin
        n_chk++;
        if (rsp_data !== ed) begin
          n_fail++;
          $display("FAIL rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, ed);
        end
      end
      blk = draining || flush;
      er0 = !blk && req0_valid && (!req1_valid || prio0);
      er1 = !blk && req1_valid && (!req0_valid || !prio0);
      n_chk++;
      if ({req0_ready, req1_ready} !== {er0, er1}) begin
        n_fail++;
        $display("FAIL ready cyc=%0d got=%b%b exp=%b%b", cyc, req0_ready, req1_ready, er0, er1);
      end
      pend_v = er0 || er1;
      if (er0) begin
        pend_own = 0; pend_dec = req0_dec; pend_data = req0_data; pend_key = req0_key; prio0 = 0;
      end else if (er1) begin
        pend_own = 1; pend_dec = req1_dec; pend_data = req1_data; pend_key = req1_key; prio0 = 1;
      end
      if (fd_exp) draining = 0;
      else if (flush) draining = 1;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic new0(input logic d);
    req0_dec = d; req0_data = rnd128(); req0_key = rnd128();
  endtask

  task automatic new1(input logic d);
    req1_dec = d; req1_data = rnd128(); req1_key = rnd128();
  endtask

  task automatic do_reset();
    tick(); RST = 1'b1;
    tick(); RST = 1'b0;
  endtask

  task automatic settle();
    req0_valid = 0; req1_valid = 0; flush = 0;
    repeat (LATENCY + 4) tick();
  endtask

  task automatic test_reset();
    RST = 1'b1; req0_valid = 1; req1_valid = 1; new0(1); new1(1);
    repeat (3) tick();
    @(negedge CLK);
    n_chk++;
    if ({core_valid, rsp0_valid, rsp1_valid, flush_done, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b%b%b%b%b exp=00000", core_valid, rsp0_valid, rsp1_valid, flush_done, busy);
    end
    n_chk++;
    if (core_data !== '0 || core_key !== '0 || rsp_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", core_data, core_key, rsp_data);
    end
    tick(); RST = 1'b0;
    @(negedge CLK);
    n_chk++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_prio got=%b%b exp=10", req0_ready, req1_ready);
    end
    settle();
  endtask

  task automatic test_single();
    logic [127:0] d, k;
    int lat;
    d = 128'h0123456789ABCDEFFEDCBA9876543210;
    k = rnd128();
    tick(); req0_valid = 1; req0_dec = 0; req0_data = d; req0_key = k;
    @(negedge CLK);
    n_chk++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_ready got=%b exp=1", req0_ready);
    end
    tick(); req0_valid = 0;
    @(negedge CLK);
    n_chk++;
    if (core_valid !== 1'b1 || core_data !== d || core_dec !== 1'b0) begin
      n_fail++; $display("FAIL single_issue got=%b/%h exp=1/%h", core_valid, core_data, d);
    end
    lat = -1;
    for (int i = 1; i <= LATENCY + 4 && lat < 0; i++) begin
      @(negedge CLK);
      if (rsp0_valid) begin
        lat = i;
        n_chk++;
        if (rsp_data !== core_fn(1'b0, d, k)) begin
          n_fail++; $display("FAIL single_data got=%h exp=%h", rsp_data, core_fn(1'b0, d, k));
        end
      end
    end
    n_chk++;
    if (lat != LATENCY) begin
      n_fail++; $display("FAIL single_latency got=%0d exp=%0d", lat, LATENCY);
    end
    settle();
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    req0_valid = 1; req1_valid = 1; new0(0); new1(1);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      g = req0_ready ? 0 : (req1_ready ? 1 : 2);
      n_chk++;
      if (g != i % 2) begin
        n_fail++; $display("FAIL rr_grant idx=%0d got=%0d exp=%0d", i, g, i % 2);
      end
      tick();
      if (g == 0) new0(1'($urandom));
      if (g == 1) new1(1'($urandom));
    end
    settle();
  endtask

  task automatic test_flush();
    int last_rsp, fd;
    for (int i = 0; i < 5; i++) begin
      tick(); req0_valid = 1; new0(1'($urandom));
    end
    tick(); flush = 1; new0(0);
    @(negedge CLK);
    n_chk++;
    if (req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready_now got=%b exp=0", req0_ready);
    end
    tick(); flush = 0;
    last_rsp = -1; fd = -1;
    for (int i = 1; i <= LATENCY + 10 && fd < 0; i++) begin
      @(negedge CLK);
      if (rsp0_valid || rsp1_valid) last_rsp = i;
      if (flush_done) fd = i;
      n_chk++;
      if (req0_ready !== 1'b0) begin
        n_fail++; $display("FAIL drain_ready i=%0d got=%b exp=0", i, req0_ready);
      end
    end
    n_chk++;
    if (fd < 0 || fd != last_rsp + 1) begin
      n_fail++; $display("FAIL flush_done_time got=%0d exp=%0d", fd, last_rsp + 1);
    end
    @(negedge CLK);
    n_chk++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_flush_ready got=%b exp=1", req0_ready);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      tick(); req0_valid = 1; req1_valid = (i == 1); new0(0); new1(1);
    end
    tick(); req0_valid = 0; req1_valid = 0;
    tick(); RST = 1;
    tick(); RST = 0;
    for (int i = 1; i <= LATENCY + 4; i++) begin
      @(negedge CLK);
      n_chk++;
      if (rsp0_valid || rsp1_valid || busy) begin
        n_fail++; $display("FAIL post_reset_quiet i=%0d got=%b%b%b exp=000", i, rsp0_valid, rsp1_valid, busy);
      end
    end
    tick(); req0_valid = 1; req1_valid = 1; new0(0); new1(0);
    @(negedge CLK);
    n_chk++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL post_reset_grant got=%b%b exp=10", req0_ready, req1_ready);
    end
    settle();
  endtask

  task automatic test_same_cycle();
    tick(); req0_valid = 1; new0(0);
    tick(); req0_valid = 0;
    repeat (LATENCY - 2) tick();
    tick(); req0_valid = 1; new0(1);
    tick(); req0_valid = 0;
    @(negedge CLK);
    n_chk++;
    if (!(core_valid && rsp0_valid)) begin
      n_fail++; $display("FAIL coincide got=%b%b exp=11", core_valid, rsp0_valid);
    end
    for (int i = 1; i <= LATENCY + 2; i++) begin
      @(negedge CLK);
      n_chk++;
      if (busy !== (i <= LATENCY)) begin
        n_fail++; $display("FAIL coincide_busy i=%0d got=%b exp=%b", i, busy, i <= LATENCY);
      end
    end
    settle();
  endtask

  task automatic test_random(input int n);
    bit a0, a1;
    a0 = 1; a1 = 1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (!req0_valid || a0) begin req0_valid = ($urandom_range(0, 2) != 0); new0(1'($urandom)); end
      if (!req1_valid || a1) begin req1_valid = ($urandom_range(0, 2) != 0); new1(1'($urandom)); end
      flush = ($urandom_range(0, 59) == 0);
      @(negedge CLK);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      n_chk++;
      if (req0_ready && req1_ready) begin
        n_fail++; $display("FAIL ready_excl i=%0d got=11 exp=not11", i);
      end
    end
    settle();
    @(negedge CLK);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL random_idle got=%b exp=0", busy);
    end
  endtask

`ifdef CAMELLIA_SCHED_STATS_EN
  task automatic test_stats();
    logic [4:0] pat;
    pat = 5'b01010;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1; new0(pat[i]);
      tick();
    end
    req0_valid = 0;
    repeat (3) tick();
    @(negedge CLK);
    n_chk++;
    if (enc_count !== 32'd3 || dec_count !== 32'd2) begin
      n_fail++; $display("FAIL stats_directed got=%0d/%0d exp=3/2", enc_count, dec_count);
    end
    settle();
  endtask
`endif

  initial begin
    RST = 1; flush = 0; core_res = '0;
    req0_valid = 0; req0_dec = 0; req0_data = '0; req0_key = '0;
    req1_valid = 0; req1_dec = 0; req1_data = '0; req1_key = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_flush();
    test_reset_mid();
    test_same_cycle();
    test_random(600);
`ifdef CAMELLIA_SCHED_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
